// File: rtl/lcd_hd44780_ctrl_pkg.sv
// Shared definitions for the HD44780 character LCD controller: command bytes,
// FSM and bus-phase encodings, and the power-up command table.
package lcd_hd44780_ctrl_pkg;

  localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam int INIT_LEN = 6;

  // Function set is repeated three times so the panel syncs to 8-bit mode
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY
  };

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_IDLE,
    ST_CLR,
    ST_ADDR,
    ST_DATA
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN_HI,
    PH_WAIT
  } bus_phase_t;

  // Row 1 starts at DDRAM 0x40, so the row bit lands on address bit 6
  function automatic logic [6:0] ddram_addr(input logic row, input logic [3:0] col);
    return {row, 2'b00, col};
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Host-side request port of the LCD controller: character writes and clear
// requests sharing one ready, plus the sticky init-complete flag.
interface lcd_hd44780_ctrl_if;
  logic       wr_valid;
  logic       wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clr_valid;
  logic       wr_ready;
  logic       init_done;

  modport master (
    output wr_valid, wr_row, wr_col, wr_char, clr_valid,
    input  wr_ready, init_done
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_char, clr_valid,
    output wr_ready, init_done
  );
endinterface

// File: rtl/lcd_hd44780_bus.sv
// One HD44780 byte transfer: setup with EN low, EN strobe, then the command
// execution wait; RS/DATA stay on the pins until the next transfer starts.
module lcd_hd44780_bus
  import lcd_hd44780_ctrl_pkg::*;
#(
  parameter int T_SETUP   = 5,
  parameter int T_EN_HIGH = 25,
  parameter int T_CMD     = 2_000,
  parameter int T_CLEAR   = 82_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       busy,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam logic [19:0] LOAD_SETUP = 20'(T_SETUP - 1);
  localparam logic [19:0] LOAD_EN    = 20'(T_EN_HIGH - 1);
  localparam logic [19:0] LOAD_CMD   = 20'(T_CMD - 1);
  localparam logic [19:0] LOAD_CLEAR = 20'(T_CLEAR - 1);

  bus_phase_t  phase;
  logic [19:0] cnt;
  logic        long_q;

  // Each phase loads its length minus one, so a phase lasts exactly T cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      done     <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      done <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (start) begin
            phase    <= PH_SETUP;
            cnt      <= LOAD_SETUP;
            lcd_rs   <= rs;
            lcd_data <= data;
            long_q   <= long_wait;
          end
        end
        PH_SETUP: begin
          if (cnt == '0) begin
            phase  <= PH_EN_HI;
            cnt    <= LOAD_EN;
            lcd_en <= 1'b1;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        PH_EN_HI: begin
          if (cnt == '0) begin
            phase  <= PH_WAIT;
            cnt    <= long_q ? LOAD_CLEAR : LOAD_CMD;
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        PH_WAIT: begin
          if (cnt == '0) begin
            phase <= PH_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

  assign busy = (phase != PH_IDLE);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 LCD controller: power-up wait, init command sequence, then
// character writes with automatic DDRAM addressing and clear requests.
module lcd_hd44780_ctrl
  import lcd_hd44780_ctrl_pkg::*;
#(
  parameter int T_POWERUP = 1_000_000,
  parameter int T_SETUP   = 5,
  parameter int T_EN_HIGH = 25,
  parameter int T_CMD     = 2_000,
  parameter int T_CLEAR   = 82_000
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_hd44780_ctrl_if.slave   host,
  inout  wire  [7:0]          lcd_data,
  output logic                lcd_en,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_on,
  output logic                lcd_blon
);

  localparam logic [19:0] LOAD_PWR = 20'(T_POWERUP - 1);
  localparam logic [2:0]  INIT_LAST = 3'(INIT_LEN - 1);

  ctrl_state_t state;
  logic [19:0] pwr_cnt;
  logic [2:0]  init_idx;
  logic [6:0]  cursor;
  logic [6:0]  target;
  logic [7:0]  char_q;
  logic        start;
  logic        cmd_rs;
  logic [7:0]  cmd_byte;
  logic        ready;
  logic        init_done;

  logic        bus_busy;
  logic        bus_done;
  logic        long_wait;
  logic [7:0]  bus_data;
  logic [6:0]  req_addr;

  assign req_addr  = ddram_addr(host.wr_row, host.wr_col);
  assign long_wait = !cmd_rs && (cmd_byte == CMD_CLEAR);

  // Every byte is launched by a one-cycle start pulse and retired on bus_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PWR;
      pwr_cnt   <= LOAD_PWR;
      init_idx  <= '0;
      cursor    <= '0;
      target    <= '0;
      char_q    <= '0;
      start     <= 1'b0;
      cmd_rs    <= 1'b0;
      cmd_byte  <= '0;
      ready     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_PWR: begin
          if (pwr_cnt == '0) begin
            state    <= ST_INIT;
            init_idx <= '0;
            start    <= 1'b1;
            cmd_rs   <= 1'b0;
            cmd_byte <= INIT_ROM[0];
          end else begin
            pwr_cnt <= pwr_cnt - 20'd1;
          end
        end
        ST_INIT: begin
          if (bus_done) begin
            if (init_idx == INIT_LAST) begin
              state     <= ST_IDLE;
              init_done <= 1'b1;
              ready     <= 1'b1;
            end else begin
              init_idx <= init_idx + 3'd1;
              start    <= 1'b1;
              cmd_byte <= INIT_ROM[init_idx + 3'd1];
            end
          end
        end
        ST_IDLE: begin
          // Clear has priority; a simultaneous write waits for ready to return
          if (ready && !bus_busy) begin
            if (host.clr_valid) begin
              state    <= ST_CLR;
              ready    <= 1'b0;
              start    <= 1'b1;
              cmd_rs   <= 1'b0;
              cmd_byte <= CMD_CLEAR;
            end else if (host.wr_valid) begin
              ready  <= 1'b0;
              target <= req_addr;
              char_q <= host.wr_char;
              start  <= 1'b1;
              if (req_addr != cursor) begin
                state    <= ST_ADDR;
                cmd_rs   <= 1'b0;
                cmd_byte <= CMD_SET_DDRAM | {1'b0, req_addr};
              end else begin
                state    <= ST_DATA;
                cmd_rs   <= 1'b1;
                cmd_byte <= host.wr_char;
              end
            end
          end
        end
        ST_CLR: begin
          if (bus_done) begin
            cursor <= '0;
            state  <= ST_IDLE;
            ready  <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (bus_done) begin
            cursor   <= target;
            state    <= ST_DATA;
            start    <= 1'b1;
            cmd_rs   <= 1'b1;
            cmd_byte <= char_q;
          end
        end
        ST_DATA: begin
          // The panel auto-increments after a data write; track it to skip address cycles
          if (bus_done) begin
            cursor <= cursor + 7'd1;
            state  <= ST_IDLE;
            ready  <= 1'b1;
          end
        end
        default: state <= ST_PWR;
      endcase
    end
  end

  lcd_hd44780_bus #(
    .T_SETUP   (T_SETUP),
    .T_EN_HIGH (T_EN_HIGH),
    .T_CMD     (T_CMD),
    .T_CLEAR   (T_CLEAR)
  ) u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rs        (cmd_rs),
    .data      (cmd_byte),
    .long_wait (long_wait),
    .busy      (bus_busy),
    .done      (bus_done),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_data  (bus_data)
  );

  assign lcd_data       = bus_data;
  assign lcd_rw         = 1'b0;
  assign lcd_on         = 1'b1;
  assign lcd_blon       = 1'b1;
  assign host.wr_ready  = ready;
  assign host.init_done = init_done;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl: a pin monitor records every EN
// strobe, and a cursor-tracking model of the panel predicts bytes and timing.
module tb_lcd_hd44780_ctrl;

  localparam int T_POWERUP = 100;
  localparam int T_SETUP   = 2;
  localparam int T_EN_HIGH = 3;
  localparam int T_CMD     = 10;
  localparam int T_CLEAR   = 40;

  localparam int WR_LAT  = T_SETUP + T_EN_HIGH + T_CMD + 2;
  localparam int CLR_LAT = T_SETUP + T_EN_HIGH + T_CLEAR + 2;
  localparam int GAP_CMD = T_CMD + 2 + T_SETUP;
  localparam int GAP_CLR = T_CLEAR + 2 + T_SETUP;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  wire  [7:0] lcd_data;
  logic       lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;

  lcd_hd44780_ctrl_if host ();

  lcd_hd44780_ctrl #(
    .T_POWERUP (T_POWERUP),
    .T_SETUP   (T_SETUP),
    .T_EN_HIGH (T_EN_HIGH),
    .T_CMD     (T_CMD),
    .T_CLEAR   (T_CLEAR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (host),
    .lcd_data (lcd_data),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_on   (lcd_on),
    .lcd_blon (lcd_blon)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] rise_val;
    logic [8:0] fall_val;
    int         width;
    int         gap;
    int         rise_cyc;
    logic       done_at_fall;
  } obs_t;

  typedef struct {
    logic [8:0] val;
    int         gap_lo;
    int         gap_hi;
    logic       done_exp;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   chk_ptr = 0;
  int   total = 0;
  int   bad = 0;
  int   model_cursor = 0;

  logic       in_init = 1'b0;
  int         ready_bad = 0;
  logic       prev_en = 1'b0;
  logic       fall_seen = 1'b0;
  int         rise_at = 0;
  int         fall_at = 0;
  logic [8:0] rise_val = '0;
  obs_t       rec;

  // Pin monitor: one record per completed EN strobe, sampled on the falling clock edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en   = 1'b0;
        fall_seen = 1'b0;
      end else begin
        if (lcd_en && !prev_en) begin
          rise_at  = cyc;
          rise_val = {lcd_rs, lcd_data};
        end
        if (!lcd_en && prev_en) begin
          rec.rise_val     = rise_val;
          rec.fall_val     = {lcd_rs, lcd_data};
          rec.width        = cyc - rise_at;
          rec.gap          = fall_seen ? rise_at - fall_at : -1;
          rec.rise_cyc     = rise_at;
          rec.done_at_fall = host.init_done;
          obs_q.push_back(rec);
          fall_at   = cyc;
          fall_seen = 1'b1;
        end
        prev_en = lcd_en;
        if (in_init && host.wr_ready && !host.init_done) ready_bad++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic cv, input logic row,
                               input logic [3:0] col, input logic [7:0] ch);
    host.wr_valid  = wv;
    host.clr_valid = cv;
    host.wr_row    = row;
    host.wr_col    = col;
    host.wr_char   = ch;
  endtask

  task automatic expect_byte(input logic rs, input logic [7:0] d, input int lo, input int hi, input logic dn);
    exp_t e;
    e.val      = {rs, d};
    e.gap_lo   = lo;
    e.gap_hi   = hi;
    e.done_exp = dn;
    exp_q.push_back(e);
  endtask

  // Panel model: DDRAM address row*64+col, address command only when it differs from the cursor
  task automatic model_write(input logic row, input logic [3:0] col, input logic [7:0] ch,
                             input int lo, input int hi, output int lat);
    int tgt;
    tgt = (row ? 64 : 0) + int'(col);
    if (tgt != model_cursor) begin
      expect_byte(1'b0, 8'(128 + tgt), lo, hi, 1'b1);
      expect_byte(1'b1, ch, GAP_CMD, GAP_CMD, 1'b1);
      lat = 2 * WR_LAT;
    end else begin
      expect_byte(1'b1, ch, lo, hi, 1'b1);
      lat = WR_LAT;
    end
    model_cursor = (tgt + 1) % 128;
  endtask

  task automatic checkBytes(input string tag, input int budget);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s byte count", tag), obs_q.size(), exp_q.size());
    for (int i = chk_ptr; i < exp_q.size() && i < obs_q.size(); i++) begin
      checkOutput($sformatf("%s[%0d] rs/data", tag, i), 32'(obs_q[i].rise_val), 32'(exp_q[i].val));
      checkOutput($sformatf("%s[%0d] hold", tag, i), 32'(obs_q[i].fall_val), 32'(exp_q[i].val));
      checkOutput($sformatf("%s[%0d] en width", tag, i), obs_q[i].width, T_EN_HIGH);
      checkOutput($sformatf("%s[%0d] init_done", tag, i), 32'(obs_q[i].done_at_fall), 32'(exp_q[i].done_exp));
      if (exp_q[i].gap_lo >= 0)
        checkOutput($sformatf("%s[%0d] gap obs=%0d range=%0d..%0d", tag, i, obs_q[i].gap,
                              exp_q[i].gap_lo, exp_q[i].gap_hi),
                    32'((obs_q[i].gap >= exp_q[i].gap_lo) && (obs_q[i].gap <= exp_q[i].gap_hi)), 1);
    end
    chk_ptr = exp_q.size();
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!host.wr_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s ready", tag), 32'(host.wr_ready), 1);
  endtask

  task automatic measure_ready(input string tag, input int exp_lat);
    int lat;
    checkOutput($sformatf("%s ready drop", tag), 32'(host.wr_ready), 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!host.wr_ready && lat < 500);
    checkOutput($sformatf("%s latency", tag), lat, exp_lat);
  endtask

  task automatic do_write(input string tag, input logic row, input logic [3:0] col, input logic [7:0] ch);
    int lat;
    wait_ready(tag, 500);
    model_write(row, col, ch, -1, -1, lat);
    applyStimulus(1'b1, 1'b0, row, col, ch);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    measure_ready(tag, lat);
    checkBytes(tag, 200);
  endtask

  task automatic clr_write(input string tag, input logic row, input logic [3:0] col, input logic [7:0] ch);
    int lat;
    wait_ready(tag, 500);
    expect_byte(1'b0, 8'h01, -1, -1, 1'b1);
    model_cursor = 0;
    applyStimulus(1'b1, 1'b1, row, col, ch);
    @(posedge clk);
    #1;
    host.clr_valid = 1'b0;
    measure_ready({tag, " clr"}, CLR_LAT);
    model_write(row, col, ch, GAP_CLR, GAP_CLR + 2, lat);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    measure_ready({tag, " wr"}, lat);
    checkBytes(tag, 300);
  endtask

  task automatic run_init(input string tag);
    int         rel;
    int         first;
    logic [7:0] seq [6];
    seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    first = exp_q.size();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) expect_byte(1'b0, seq[i], -1, -1, 1'b0);
      else if (seq[i-1] == 8'h01) expect_byte(1'b0, seq[i], GAP_CLR, GAP_CLR, 1'b0);
      else expect_byte(1'b0, seq[i], GAP_CMD, GAP_CMD, 1'b0);
    end
    ready_bad = 0;
    in_init   = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel   = cyc;
    checkBytes(tag, 2000);
    if (obs_q.size() > first)
      checkOutput($sformatf("%s powerup obs=%0d", tag, obs_q[first].rise_cyc - rel),
                  32'((obs_q[first].rise_cyc - rel >= T_POWERUP + T_SETUP) &&
                      (obs_q[first].rise_cyc - rel <= T_POWERUP + T_SETUP + 2)), 1);
    else
      checkOutput($sformatf("%s powerup first byte", tag), 0, 1);
    wait_ready(tag, 200);
    checkOutput($sformatf("%s init_done", tag), 32'(host.init_done), 1);
    checkOutput($sformatf("%s ready during init", tag), ready_bad, 0);
    in_init = 1'b0;
    model_cursor = 0;
  endtask

  initial begin
    int         n;
    logic       row;
    logic [3:0] col;
    logic [7:0] ch;
    int         lat;

    $display("[TB] start");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst en", 32'(lcd_en), 0);
    checkOutput("rst rs", 32'(lcd_rs), 0);
    checkOutput("rst data", 32'(lcd_data), 0);
    checkOutput("rst ready", 32'(host.wr_ready), 0);
    checkOutput("rst init_done", 32'(host.init_done), 0);
    checkOutput("rst rw", 32'(lcd_rw), 0);
    checkOutput("rst on", 32'(lcd_on), 1);
    checkOutput("rst blon", 32'(lcd_blon), 1);

    run_init("init1");

    do_write("wrA", 1'b0, 4'd0, 8'h41);
    do_write("wrB", 1'b1, 4'd3, 8'h42);
    do_write("wrC", 1'b1, 4'd4, 8'h43);
    do_write("r0c15", 1'b0, 4'd15, 8'h78);
    do_write("r1c0", 1'b1, 4'd0, 8'h79);
    do_write("r1c15", 1'b1, 4'd15, 8'h7A);
    do_write("r1c15again", 1'b1, 4'd15, 8'h77);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1 && (model_cursor < 16 || (model_cursor >= 64 && model_cursor < 80))) begin
        row = (model_cursor >= 64);
        col = 4'(model_cursor % 16);
      end else begin
        row = 1'($urandom_range(0, 1));
        col = 4'($urandom_range(0, 15));
      end
      ch = 8'($urandom_range(32, 126));
      do_write($sformatf("rnd%0d", i), row, col, ch);
    end

    clr_write("clrK", 1'b1, 4'd2, 8'h4B);
    clr_write("clrL", 1'b0, 4'd0, 8'h4C);

    // Reset while EN is high, holding a write request through the restart
    wait_ready("abort", 500);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd7, 8'h52);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    n = 0;
    while (!lcd_en && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("abort en seen", 32'(lcd_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort en", 32'(lcd_en), 0);
    checkOutput("abort init_done", 32'(host.init_done), 0);
    checkOutput("abort ready", 32'(host.wr_ready), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h51);
    repeat (3) @(posedge clk);

    run_init("init2");
    model_write(1'b0, 4'd0, 8'h51, -1, -1, lat);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    measure_ready("held", lat);
    checkBytes("held", 200);
    repeat (60) @(posedge clk);
    checkBytes("held once", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
